// File: rtl/vga_capture.sv
// Video input capture: regenerates the pixel grid from HSYNC/VSYNC, locks onto the
// timing and writes active pixels as RGB565. Define VGA_CAPTURE_FRAME_CNT_EN to add Frame_cnt.
module vga_capture #(
    parameter int H_Sync       = 44,
    parameter int H_backporch  = 148,
    parameter int H_left       = 0,
    parameter int H_data       = 1920,
    parameter int H_right      = 0,
    parameter int H_Frontporch = 88,
    parameter int H_total      = H_Sync + H_backporch + H_left + H_data + H_right + H_Frontporch,
    parameter int H_width      = $clog2(H_total) + 1,
    parameter int V_Sync       = 5,
    parameter int V_backporch  = 36,
    parameter int V_left       = 0,
    parameter int V_data       = 1080,
    parameter int V_right      = 0,
    parameter int V_Frontporch = 4,
    parameter int V_total      = V_Sync + V_backporch + V_left + V_data + V_right + V_Frontporch,
    parameter int V_width      = $clog2(V_total) + 1
) (
    input  logic               Sys_clk,
    input  logic               Rst_n,
    input  logic               H_Sync_in,
    input  logic               V_Sync_in,
    input  logic [7:0]         Red_in,
    input  logic [7:0]         Green_in,
    input  logic [7:0]         Blue_in,
    input  logic               Clr_err,
    input  logic               wdata_fifo_full,
    output logic [15:0]        wdata_fifo_wr_data,
    output logic               wdata_fifo_wr_en,
    output logic [H_width-1:0] Pix_x,
    output logic [V_width-1:0] Pix_y,
    output logic               Frame_start,
    output logic               Locked,
    output logic               Timing_err,
    output logic               Overflow
`ifdef VGA_CAPTURE_FRAME_CNT_EN
    ,
    output logic [15:0]        Frame_cnt
`endif
);

    localparam logic [1:0] ST_UNLOCK  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam int H_ACT = H_Sync + H_backporch + H_left;
    localparam int V_ACT = V_Sync + V_backporch + V_left;

    localparam logic [H_width-1:0] H_FIRST = H_width'(H_ACT);
    localparam logic [H_width-1:0] H_LAST  = H_width'(H_ACT + H_data - 1);
    localparam logic [H_width-1:0] H_TOT   = H_width'(H_total);
    localparam logic [V_width-1:0] V_FIRST = V_width'(V_ACT);
    localparam logic [V_width-1:0] V_LAST  = V_width'(V_ACT + V_data - 1);
    localparam logic [V_width-1:0] V_TOT   = V_width'(V_total);
    localparam logic [V_width-1:0] V_END   = V_width'(V_total - 1);

    logic               hs1, vs1, hs2, vs2;
    logic [15:0]        pix1;
    logic               h_rise, v_rise;
    logic [H_width-1:0] h_cnt, cur_h;
    logic [V_width-1:0] v_cnt, cur_v;
    logic [1:0]         state;
    logic               meas_bad;
    logic               line_bad, lock_err, active, capture;
    logic               unused_lsbs;

    // Low colour bits are dropped by the RGB565 packing.
    assign unused_lsbs = ^{Red_in[2:0], Green_in[1:0], Blue_in[2:0]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hs1  <= 1'b0;
            vs1  <= 1'b0;
            hs2  <= 1'b0;
            vs2  <= 1'b0;
            pix1 <= '0;
        end else begin
            hs1  <= H_Sync_in;
            vs1  <= V_Sync_in;
            hs2  <= hs1;
            vs2  <= vs1;
            pix1 <= {Red_in[7:3], Green_in[7:2], Blue_in[7:3]};
        end
    end

    assign h_rise = hs1 & ~hs2;
    assign v_rise = vs1 & ~vs2;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cur_h = h_cnt;
        cur_v = v_cnt;
        if (h_rise) begin
            cur_h = '0;
            if (v_rise)
                cur_v = '0;
            else if (v_cnt != '1)
                cur_v = v_cnt + 1'b1;
        end
    end

    // h_cnt holds the last position + 1, which is the measured line length at the next rise.
    assign line_bad = (h_rise && (h_cnt != H_TOT)) || (cur_h == H_TOT);
    assign lock_err = line_bad || (v_rise && (v_cnt != V_END)) || (cur_v == V_TOT);
    assign active   = (cur_h >= H_FIRST) && (cur_h <= H_LAST) && (cur_v >= V_FIRST) && (cur_v <= V_LAST);
    assign capture  = (state == ST_LOCKED) && !lock_err && active;
    assign Locked   = (state == ST_LOCKED);

    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= (cur_h == '1) ? cur_h : cur_h + 1'b1;
            v_cnt <= cur_v;
        end
    end

    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= ST_UNLOCK;
            meas_bad <= 1'b0;
        end else begin
            case (state)
                ST_UNLOCK: begin
                    if (v_rise) begin
                        state    <= ST_MEASURE;
                        meas_bad <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    if (v_rise) begin
                        if ((v_cnt == V_END) && !meas_bad && !line_bad)
                            state <= ST_LOCKED;
                        meas_bad <= 1'b0;
                    end else if (line_bad) begin
                        meas_bad <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (lock_err)
                        state <= ST_UNLOCK;
                end
                default: state <= ST_UNLOCK;
            endcase
        end
    end

    // NOTE: datapath registers are reset too, since every output must read 0 during reset.
    // FIFO full is sampled on the same edge that registers the write strobe.
    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wdata_fifo_wr_en   <= 1'b0;
            wdata_fifo_wr_data <= '0;
            Pix_x              <= '0;
            Pix_y              <= '0;
            Frame_start        <= 1'b0;
        end else begin
            wdata_fifo_wr_en <= capture && !wdata_fifo_full;
            Frame_start      <= capture && (cur_h == H_FIRST) && (cur_v == V_FIRST);
            if (capture) begin
                wdata_fifo_wr_data <= pix1;
                Pix_x              <= cur_h - H_FIRST;
                Pix_y              <= cur_v - V_FIRST;
            end
        end
    end

    // Sticky flags: a set event in the same cycle beats Clr_err.
    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Timing_err <= 1'b0;
            Overflow   <= 1'b0;
        end else begin
            if ((state == ST_LOCKED) && lock_err)
                Timing_err <= 1'b1;
            else if (Clr_err)
                Timing_err <= 1'b0;
            if (capture && wdata_fifo_full)
                Overflow <= 1'b1;
            else if (Clr_err)
                Overflow <= 1'b0;
        end
    end

`ifdef VGA_CAPTURE_FRAME_CNT_EN
    always_ff @(posedge Sys_clk or negedge Rst_n) begin
        if (!Rst_n)
            Frame_cnt <= '0;
        else if (Clr_err)
            Frame_cnt <= '0;
        else if ((state == ST_LOCKED) && v_rise && !lock_err)
            Frame_cnt <= Frame_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture on a reduced timing (H_total=15, V_total=8).
// Frame_cnt checks are compiled only when VGA_CAPTURE_FRAME_CNT_EN is defined.
module tb_vga_capture;

    localparam int HW = 5;
    localparam int VW = 4;

    logic          clk;
    logic          rst_n, hs, vs, clr, full;
    logic [7:0]    red, green, blue;
    logic [15:0]   wr_data;
    logic          wr_en;
    logic [HW-1:0] pix_x;
    logic [VW-1:0] pix_y;
    logic          frame_start, locked, timing_err, overflow;
`ifdef VGA_CAPTURE_FRAME_CNT_EN
    logic [15:0]   frame_cnt;
`endif

    vga_capture #(
        .H_Sync(2), .H_backporch(3), .H_left(0), .H_data(8), .H_right(0), .H_Frontporch(2),
        .V_Sync(1), .V_backporch(2), .V_left(0), .V_data(4), .V_right(0), .V_Frontporch(1)
    ) dut (
        .Sys_clk(clk),
        .Rst_n(rst_n),
        .H_Sync_in(hs),
        .V_Sync_in(vs),
        .Red_in(red),
        .Green_in(green),
        .Blue_in(blue),
        .Clr_err(clr),
        .wdata_fifo_full(full),
        .wdata_fifo_wr_data(wr_data),
        .wdata_fifo_wr_en(wr_en),
        .Pix_x(pix_x),
        .Pix_y(pix_y),
        .Frame_start(frame_start),
        .Locked(locked),
        .Timing_err(timing_err),
        .Overflow(overflow)
`ifdef VGA_CAPTURE_FRAME_CNT_EN
        ,
        .Frame_cnt(frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          stamp;
        logic        wr;
        logic        fs;
        logic [4:0]  x;
        logic [3:0]  y;
        logic [15:0] data;
    } ev_t;

    typedef struct {
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [15:0] exp565;
    } col_vec_t;

    ev_t      exp_q[$];
    ev_t      obs_q[$];
    col_vec_t col_tbl[4];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pin00   = 0;

    // Per-frame scenario knobs consumed by send_frame (-1 = off).
    int short_line = -1;
    int rst_line   = -1;
    int rst_h      = 0;
    int clr_line   = -1;
    int probe_line = -1;
    int full_x     = -1;
    int full_y     = -1;
    bit const_col  = 0;
    logic [7:0]  cr, cg, cb;
    logic [15:0] cexp;
    logic        lk_h1, lk_h2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to565(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    function automatic logic [63:0] pack(input ev_t e);
        return 64'({24'(e.stamp), e.wr, e.fs, e.x, e.y, (e.wr ? e.data : 16'h0)});
    endfunction

    task automatic check_reset_outputs(input string name);
        check(name, {wr_data, wr_en, pix_x, pix_y, frame_start, locked, timing_err, overflow}, 64'h0);
`ifdef VGA_CAPTURE_FRAME_CNT_EN
        check({name, " frame_cnt"}, frame_cnt, 64'h0);
`endif
    endtask

    // Compares the observed write/frame-start events against the expectations built by send_frame.
    task automatic check_sb(input string name, input int exp_writes, input int exp_fs);
        int n_wr = 0;
        int n_fs = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i].wr) n_wr++;
            if (obs_q[i].fs) n_fs++;
        end
        check({name, " writes"}, n_wr, exp_writes);
        check({name, " frame_starts"}, n_fs, exp_fs);
        check({name, " events"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s ev%0d", name, i), pack(obs_q[i]), pack(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        if (wr_en || frame_start) begin
            ev_t e;
            e.stamp = cyc;
            e.wr    = wr_en;
            e.fs    = frame_start;
            e.x     = pix_x;
            e.y     = pix_y;
            e.data  = wr_data;
            obs_q.push_back(e);
        end
    end

    // One frame, back to back with the next: line 0 carries VSYNC, each line HSYNC for 2 clocks.
    // A captured pixel is expected on the outputs 2 clocks after it is on the pins; FIFO full is
    // raised one clock after the targeted pixel leaves the pins.
    task automatic send_frame(input int n_lines, input bit cap);
        bit full_next = 0;
        int len;
        for (int l = 0; l < n_lines; l++) begin
            len = (l == short_line) ? 14 : 15;
            for (int h = 0; h < len; h++) begin
                @(negedge clk);
                if (l == rst_line && h == rst_h) begin
                    rst_n = 1'b0;
                    #1;
                    check_reset_outputs("mid-frame reset outputs");
                    #1;
                    rst_n = 1'b1;
                end
                hs = (h < 2);
                vs = (l == 0);
                if (const_col) begin
                    red = cr; green = cg; blue = cb;
                end else begin
                    red = 8'(l * 16 + h); green = ~red; blue = red ^ 8'h5A;
                end
                full      = full_next;
                full_next = 1'b0;
                clr       = (l == clr_line && h == 0);
                if (l == probe_line && h == 1) lk_h1 = locked;
                if (l == probe_line && h == 2) lk_h2 = locked;
                if (cap && (short_line < 0 || l <= short_line) && (rst_line < 0 || l < rst_line) &&
                    h >= 5 && h <= 12 && l >= 3 && l <= 6) begin
                    ev_t e;
                    e.stamp = cyc + 2;
                    e.x     = 5'(h - 5);
                    e.y     = 4'(l - 3);
                    e.fs    = (h == 5 && l == 3);
                    e.wr    = !((h - 5) == full_x && (l - 3) == full_y);
                    e.data  = const_col ? cexp : to565(red, green, blue);
                    if (e.fs) pin00 = cyc;
                    full_next = !e.wr;
                    if (e.wr || e.fs) exp_q.push_back(e);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        col_tbl[0] = '{r: 8'hFF, g: 8'h80, b: 8'h08, exp565: 16'hFC01};
        col_tbl[1] = '{r: 8'h00, g: 8'h00, b: 8'h00, exp565: 16'h0000};
        col_tbl[2] = '{r: 8'h12, g: 8'h34, b: 8'h56, exp565: 16'h11AA};
        col_tbl[3] = '{r: 8'hA5, g: 8'h5A, b: 8'hFF, exp565: 16'hA2DF};

        rst_n = 1'b0; hs = 1'b0; vs = 1'b0; clr = 1'b0; full = 1'b0;
        red = '0; green = '0; blue = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("power-on reset outputs");
        rst_n = 1'b1;

        // Test 1: clean frames, lock at the second V rise.
        send_frame(8, 0);
        check("t1 locked after 1st V", locked, 0);
        check_sb("t1 f1", 0, 0);
        probe_line = 0;
        send_frame(8, 1);
        probe_line = -1;
        check("t1 locked before 2nd V takes effect", lk_h1, 0);
        check("t1 locked after 2nd V", lk_h2, 1);
        check("t1 first write latency", (obs_q.size() > 0) ? obs_q[0].stamp - pin00 : -1, 2);
        check_sb("t1 f2", 32, 1);
        send_frame(8, 1);
        check_sb("t1 f3", 32, 1);
        check("t1 locked", locked, 1);
        check("t1 timing_err", timing_err, 0);

        // Test 2: RGB565 packing on constant-colour frames.
        const_col = 1;
        for (int i = 0; i < 4; i++) begin
            cr = col_tbl[i].r; cg = col_tbl[i].g; cb = col_tbl[i].b; cexp = col_tbl[i].exp565;
            send_frame(8, 1);
            check_sb($sformatf("t2 colour%0d", i), 32, 1);
        end
        const_col = 0;

        // Test 4: FIFO full drops exactly the pixel at x=3,y=1.
        full_x = 3; full_y = 1;
        send_frame(8, 1);
        full_x = -1; full_y = -1;
        check_sb("t4 full frame", 31, 1);
        check("t4 overflow set", overflow, 1);
        check("t4 still locked", locked, 1);
        clr_line = 1;
        send_frame(8, 1);
        clr_line = -1;
        check("t4 overflow cleared", overflow, 0);
        check_sb("t4 after clear", 32, 1);

        // Test 3: a 14-clock line inside a locked frame.
        short_line = 4; probe_line = 5;
        send_frame(8, 1);
        short_line = -1; probe_line = -1;
        check("t3 locked until error seen", lk_h1, 1);
        check("t3 unlocked next cycle", lk_h2, 0);
        check("t3 timing_err", timing_err, 1);
        check_sb("t3 short frame", 16, 1);
        send_frame(8, 0);
        check("t3 measuring", locked, 0);
        check("t3 timing_err sticky", timing_err, 1);
        check_sb("t3 measure frame", 0, 0);
        clr_line = 1;
        send_frame(8, 1);
        clr_line = -1;
        check("t3 relocked", locked, 1);
        check("t3 timing_err cleared", timing_err, 0);
        check_sb("t3 relock frame", 32, 1);

        // Test 5: reset mid-line while locked (line y=1, before its active pixels).
        rst_line = 4; rst_h = 3;
        send_frame(8, 1);
        rst_line = -1;
        check("t5 unlocked after reset", locked, 0);
        check_sb("t5 reset frame", 8, 1);
        send_frame(8, 0);
        check("t5 measuring", locked, 0);
        check_sb("t5 measure frame", 0, 0);
        send_frame(8, 1);
        check("t5 relocked", locked, 1);
        check_sb("t5 relock frame", 32, 1);

`ifdef VGA_CAPTURE_FRAME_CNT_EN
        // Test 6: frame counter over five captured frames, then a 9-line frame.
        rst_line = 7; rst_h = 3;
        send_frame(8, 1);
        rst_line = -1;
        check_sb("t6 reset frame", 32, 1);
        check("t6 frame_cnt reset", frame_cnt, 0);
        send_frame(8, 0);
        check_sb("t6 measure frame", 0, 0);
        for (int f = 0; f < 5; f++) begin
            send_frame(8, 1);
            check_sb($sformatf("t6 frame%0d", f), 32, 1);
        end
        send_frame(9, 1);
        check("t6 frame_cnt after 5", frame_cnt, 5);
        check("t6 unlocked by long frame", locked, 0);
        check("t6 timing_err", timing_err, 1);
        check_sb("t6 long frame", 32, 1);
        send_frame(8, 0);
        check("t6 frame_cnt holds", frame_cnt, 5);
        check_sb("t6 unlock frame", 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
